// File: rtl/sa_pkg.sv
// Constants and state encoding shared by the systolic-array sequencer and the array.
package sa_pkg;

    localparam int unsigned SA_N  = 4;
    localparam int unsigned SA_DW = 4;
    localparam int unsigned SA_RW = 2 * SA_DW;

    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_HOLD} sa_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// One lane of operand skew: DEPTH-stage delay of data plus a valid bit per stage.
// The output is forced to zero whenever the last stage holds no valid data.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int unsigned DW    = SA_DW,
    parameter int unsigned DEPTH = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset_n;
        assign out_data = in_valid ? in_data : '0;
    end else begin : g_pipe
        logic [DEPTH-1:0]         vld_q;
        logic [DEPTH-1:0][DW-1:0] dat_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q <= '0;
                dat_q <= '0;
            end else begin
                vld_q[0] <= in_valid;
                dat_q[0] <= in_data;
                for (int s = 1; s < DEPTH; s++) begin
                    vld_q[s] <= vld_q[s-1];
                    dat_q[s] <= dat_q[s-1];
                end
            end
        end

        assign out_data = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;
    end

endmodule

// File: rtl/sa_seq_ctrl.sv
// Sequencer for the NxN output-stationary systolic MAC array: feed, drain, hold results.
// Optional busy-cycle counter (perf_cycles) is built when SA_CYCLE_CNT_EN is defined.
module sa_seq_ctrl
    import sa_pkg::*;
#(
    parameter int unsigned N     = SA_N,
    parameter int unsigned DW    = SA_DW,
    parameter int unsigned K_MAX = 16,
    parameter int unsigned AW    = $clog2(K_MAX)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [AW:0]     k_len,
    output logic            busy,
    output logic            done,
    input  logic            result_ack,
    output logic            a_rd_en,
    output logic [AW-1:0]   a_rd_addr,
    input  logic [N*DW-1:0] a_rd_data,
    output logic            b_rd_en,
    output logic [AW-1:0]   b_rd_addr,
    input  logic [N*DW-1:0] b_rd_data,
    output logic [N*DW-1:0] arr_weight,
    output logic [N*DW-1:0] arr_data,
    output logic            arr_compute_en
`ifdef SA_CYCLE_CNT_EN
    ,
    output logic [15:0]     perf_cycles
`endif
);

    localparam int unsigned DCW = $clog2(2 * N);

    sa_state_e      state;
    logic [AW:0]    k_len_q;
    logic [AW:0]    k_cnt;
    logic [DCW-1:0] drain_cnt;
    logic [AW:0]    k_clamped;
    logic           rd_vld_q;

    assign k_clamped = (k_len > (AW+1)'(K_MAX)) ? (AW+1)'(K_MAX) : k_len;
    assign b_rd_en   = a_rd_en;
    assign b_rd_addr = a_rd_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            k_len_q        <= '0;
            k_cnt          <= '0;
            drain_cnt      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            a_rd_en        <= 1'b0;
            a_rd_addr      <= '0;
            arr_compute_en <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        arr_compute_en <= 1'b1;
                        drain_cnt      <= '0;
                        k_len_q        <= k_clamped;
                        if (k_clamped != '0) begin
                            state     <= ST_FEED;
                            k_cnt     <= (AW+1)'(1);
                            a_rd_en   <= 1'b1;
                            a_rd_addr <= '0;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_FEED: begin
                    // k_cnt counts reads already issued, including the current one
                    if (k_cnt == k_len_q) begin
                        state     <= ST_DRAIN;
                        a_rd_en   <= 1'b0;
                        a_rd_addr <= '0;
                    end else begin
                        a_rd_addr <= k_cnt[AW-1:0];
                        k_cnt     <= k_cnt + (AW+1)'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DCW'(2 * N - 2)) begin
                        state <= ST_HOLD;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                ST_HOLD: begin
                    if (result_ack) begin
                        state          <= ST_IDLE;
                        busy           <= 1'b0;
                        done           <= 1'b0;
                        arr_compute_en <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Buffer data is valid one cycle after the read strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= a_rd_en;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        sa_skew_line #(
            .DW    (DW),
            .DEPTH (i)
        ) u_skew_a (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_valid (rd_vld_q),
            .in_data  (a_rd_data[i*DW +: DW]),
            .out_data (arr_weight[i*DW +: DW])
        );

        sa_skew_line #(
            .DW    (DW),
            .DEPTH (i)
        ) u_skew_b (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_valid (rd_vld_q),
            .in_data  (b_rd_data[i*DW +: DW]),
            .out_data (arr_data[i*DW +: DW])
        );
    end

`ifdef SA_CYCLE_CNT_EN
    logic [15:0] cyc_q;
    logic [15:0] cyc_inc;

    assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q       <= '0;
            perf_cycles <= '0;
        end else if (state == ST_IDLE) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_inc;
            if (state == ST_HOLD && result_ack) begin
                perf_cycles <= cyc_inc;
            end
        end
    end
`endif

endmodule
